pzvip_gpio_port_ctrl: RTL and testbench

//  Parametrised GPIO port controller for testbench and emulation models.
//  - Drives value_out/output_enable from masked register writes.
//  - Synchronises and debounces value_in per bit.
//  - Detects rise/fall edges on the filtered value into sticky per-bit status and one irq line.
//  - Sits between a pzvip_gpio_if instance and the sequencer/agent register layer.

---
 rtl/pzvip_gpio_port_ctrl_pkg.sv | 22 ++
 rtl/pzvip_gpio_port_ctrl_if.sv | 11 +
 rtl/pzvip_gpio_port_ctrl_bit_filter.sv | 60 ++++++
 rtl/pzvip_gpio_port_ctrl.sv | 104 ++++++++++
 tb/tb_pzvip_gpio_port_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pzvip_gpio_port_ctrl_pkg.sv
// Shared types and helpers for the GPIO port controller.
// PZVIP_GPIO_MAX_WIDTH bounds the WIDTH parameter (defaults to 64 when not set by the build).
`ifndef PZVIP_GPIO_MAX_WIDTH
`define PZVIP_GPIO_MAX_WIDTH 64
`endif

package pzvip_gpio_port_pkg;

  typedef logic [`PZVIP_GPIO_MAX_WIDTH-1:0] pzvip_gpio_word_t;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } pzvip_gpio_edge_e;

  // Cycles after reset release during which the filter tracks the synchroniser directly.
  function automatic int unsigned settle_cycles(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/pzvip_gpio_port_ctrl_if.sv
// Pad-side GPIO bundle: master is the port controller, slave is the pad/environment model.
interface pzvip_gpio_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] value_out;
  logic [WIDTH-1:0] output_enable;

  modport master (input value_in, output value_out, output output_enable);
  modport slave  (output value_in, input value_out, input output_enable);
endinterface

// File: rtl/pzvip_gpio_port_ctrl_bit_filter.sv
// Per-bit input synchroniser and debounce filter; reports the edge taken on the filter update.
module pzvip_gpio_bit_filter
  import pzvip_gpio_port_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      settling,
  input  logic                      sync_in,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles,
  output logic                      filtered,
  output pzvip_gpio_edge_e          edge_kind
);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q;
  logic                      filtered_q;
  logic                      s;
  logic                      mismatch;
  logic                      hit;
  logic [DEBOUNCE_WIDTH:0]   cnt_inc;

  assign s        = sync_q[SYNC_STAGES-1];
  assign filtered = filtered_q;

  // Extra bit on the increment keeps the threshold compare exact even at counter max.
  always_comb begin
    mismatch  = (s != filtered_q);
    cnt_inc   = {1'b0, cnt_q} + (DEBOUNCE_WIDTH+1)'(1);
    hit       = (cnt_inc >= {1'b0, debounce_cycles});
    edge_kind = EDGE_NONE;
    if (!settling && mismatch && hit) begin
      edge_kind = s ? EDGE_RISE : EDGE_FALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      filtered_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sync_in};
      if (settling) begin
        filtered_q <= s;
        cnt_q      <= '0;
      end else if (!mismatch) begin
        cnt_q <= '0;
      end else if (hit) begin
        filtered_q <= s;
        cnt_q      <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_inc[DEBOUNCE_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/pzvip_gpio_port_ctrl.sv
// GPIO port controller: masked output writes, debounced inputs, sticky edge status and irq.
// Define PZVIP_GPIO_LOOPBACK_EN to make driven bits read back their own output.
module pzvip_gpio_port_ctrl
  import pzvip_gpio_port_pkg::*;
#(
  parameter int unsigned      WIDTH           = 32,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_WIDTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_OE        = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  pzvip_gpio_if.master              gpio,
  input  logic                      out_we,
  input  logic [WIDTH-1:0]          out_wdata,
  input  logic [WIDTH-1:0]          out_wmask,
  input  logic                      oe_we,
  input  logic [WIDTH-1:0]          oe_wdata,
  input  logic [DEBOUNCE_WIDTH-1:0] debounce_cycles,
  input  logic [WIDTH-1:0]          irq_rise_en,
  input  logic [WIDTH-1:0]          irq_fall_en,
  input  logic [WIDTH-1:0]          irq_clear,
  output logic [WIDTH-1:0]          value_filtered,
  output logic [WIDTH-1:0]          irq_status,
  output logic                      irq
);

  localparam int unsigned SETTLE_LEN = settle_cycles(SYNC_STAGES);
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_LEN + 1);

  logic [WIDTH-1:0]    value_out_q;
  logic [WIDTH-1:0]    oe_q;
  logic [WIDTH-1:0]    sync_in;
  logic [SETTLE_W-1:0] settle_q;
  logic                settling;
  logic [WIDTH-1:0]    event_set;
  logic [WIDTH-1:0]    status_next;
  pzvip_gpio_edge_e    edge_kind [WIDTH];

  assign gpio.value_out     = value_out_q;
  assign gpio.output_enable = oe_q;
  assign settling           = (settle_q != '0);

`ifdef PZVIP_GPIO_LOOPBACK_EN
  assign sync_in = (oe_q & value_out_q) | (~oe_q & gpio.value_in);
`else
  assign sync_in = gpio.value_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      value_out_q <= RESET_VALUE_OUT;
      oe_q        <= RESET_OE;
      settle_q    <= SETTLE_W'(SETTLE_LEN);
    end else begin
      if (out_we) begin
        value_out_q <= (value_out_q & ~out_wmask) | (out_wdata & out_wmask);
      end
      if (oe_we) begin
        oe_q <= oe_wdata;
      end
      if (settling) begin
        settle_q <= settle_q - SETTLE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pzvip_gpio_bit_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_filter (
      .clk             (clk),
      .reset           (reset),
      .settling        (settling),
      .sync_in         (sync_in[i]),
      .debounce_cycles (debounce_cycles),
      .filtered        (value_filtered[i]),
      .edge_kind       (edge_kind[i])
    );
  end

  // Set is OR-ed in after the clear so an event on the clearing edge survives.
  always_comb begin
    event_set = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      event_set[i] = ((edge_kind[i] == EDGE_RISE) && irq_rise_en[i]) ||
                     ((edge_kind[i] == EDGE_FALL) && irq_fall_en[i]);
    end
    status_next = (irq_status & ~irq_clear) | event_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= status_next;
      irq        <= |status_next;
    end
  end

endmodule

// File: tb/tb_pzvip_gpio_port_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a run-length reference model.
module tb_pzvip_gpio_port_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          out_we, oe_we;
  logic [W-1:0]  out_wdata, out_wmask, oe_wdata;
  logic [DW-1:0] debounce_cycles;
  logic [W-1:0]  irq_rise_en, irq_fall_en, irq_clear;
  logic [W-1:0]  value_filtered, irq_status;
  logic          irq;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model state
  logic [W-1:0] m_vout, m_oe, m_filt, m_status;
  logic         m_irq;
  int unsigned  n_edges;
  logic [W-1:0] sin_hist[$];
  logic [W-1:0] s_hist[$];

  always #5 clk = ~clk;

  pzvip_gpio_if #(.WIDTH(W)) gpio ();

  pzvip_gpio_port_ctrl #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_WIDTH  (DW),
    .RESET_VALUE_OUT ('0),
    .RESET_OE        ('0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .gpio            (gpio.master),
    .out_we          (out_we),
    .out_wdata       (out_wdata),
    .out_wmask       (out_wmask),
    .oe_we           (oe_we),
    .oe_wdata        (oe_wdata),
    .debounce_cycles (debounce_cycles),
    .irq_rise_en     (irq_rise_en),
    .irq_fall_en     (irq_fall_en),
    .irq_clear       (irq_clear),
    .value_filtered  (value_filtered),
    .irq_status      (irq_status),
    .irq             (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Model: filtered takes s once s has differed from it for max(debounce,1) consecutive post-settle edges.
  task automatic model_edge();
    logic [W-1:0] sin, s_pre, set, nf;
    int unsigned  need, run;
    if (reset) begin
      m_vout = '0; m_oe = '0; m_filt = '0; m_status = '0; m_irq = 1'b0;
      n_edges = 0;
      sin_hist.delete();
      s_hist.delete();
      return;
    end
`ifdef PZVIP_GPIO_LOOPBACK_EN
    sin = (m_oe & m_vout) | (~m_oe & gpio.value_in);
`else
    sin = gpio.value_in;
`endif
    n_edges++;
    s_pre = (n_edges > SS) ? sin_hist[n_edges-1-SS] : '0;
    sin_hist.push_back(sin);
    s_hist.push_back(s_pre);
    set = '0;
    nf  = m_filt;
    if (n_edges <= SS + 1) begin
      nf = s_pre;
    end else begin
      need = (debounce_cycles == 0) ? 1 : int'(debounce_cycles);
      for (int b = 0; b < W; b++) begin
        run = 0;
        for (int j = int'(n_edges); j >= int'(SS) + 2; j--) begin
          if (s_hist[j-1][b] == m_filt[b]) break;
          run++;
        end
        if (run >= need) begin
          nf[b] = s_pre[b];
          if (s_pre[b] && irq_rise_en[b])  set[b] = 1'b1;
          if (!s_pre[b] && irq_fall_en[b]) set[b] = 1'b1;
        end
      end
    end
    m_status = (m_status & ~irq_clear) | set;
    m_irq    = |m_status;
    m_filt   = nf;
    if (out_we) m_vout = (m_vout & ~out_wmask) | (out_wdata & out_wmask);
    if (oe_we)  m_oe   = oe_wdata;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("value_filtered", value_filtered, m_filt);
    check_eq("irq_status", irq_status, m_status);
    check_eq("irq", irq, m_irq);
    check_eq("value_out", gpio.value_out, m_vout);
    check_eq("output_enable", gpio.output_enable, m_oe);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic idle();
    out_we = 1'b0; oe_we = 1'b0; irq_clear = '0;
  endtask

  initial begin
    reset = 1'b1; idle();
    out_wdata = '0; out_wmask = '0; oe_wdata = '0;
    debounce_cycles = 8'd4; irq_rise_en = 8'hFF; irq_fall_en = 8'h00;
    gpio.value_in = 8'hFF;
    m_vout = '0; m_oe = '0; m_filt = '0; m_status = '0; m_irq = 1'b0; n_edges = 0;

    // Reset with all inputs high
    ticks(2);
    check_eq("reset_filtered", value_filtered, 8'h00);
    check_eq("reset_irq", irq, 1'b0);
    reset = 1'b0;
    ticks(3);
    check_eq("settle_filtered", value_filtered, 8'hFF);
    check_eq("settle_status", irq_status, 8'h00);
    check_eq("settle_irq", irq, 1'b0);

    // Debounce of 4 on bit0
    debounce_cycles = 8'd1; gpio.value_in = 8'h00;
    ticks(6);
    irq_clear = 8'hFF; tick(); idle();
    debounce_cycles = 8'd4; gpio.value_in = 8'h01;
    ticks(5);
    check_eq("deb4_before", value_filtered, 8'h00);
    tick();
    check_eq("deb4_rise", value_filtered, 8'h01);
    check_eq("deb4_status", irq_status, 8'h01);
    check_eq("deb4_irq", irq, 1'b1);
    gpio.value_in = 8'h00; ticks(3);
    gpio.value_in = 8'h01; ticks(8);
    check_eq("glitch_ignored", value_filtered, 8'h01);

    // Bit3: fall enabled only
    irq_rise_en = 8'h00; irq_fall_en = 8'h08; debounce_cycles = 8'd1;
    gpio.value_in = 8'h08; ticks(6);
    irq_clear = 8'hFF; tick(); idle();
    check_eq("cleared", irq_status, 8'h00);
    gpio.value_in = 8'h00; tick();
    gpio.value_in = 8'h08; ticks(8);
    check_eq("fall_only", irq_status, 8'h08);

    // Clear colliding with a new fall
    irq_clear = 8'hFF; tick(); idle();
    gpio.value_in = 8'h00; ticks(2);
    irq_clear = 8'h08; tick(); idle();
    check_eq("set_wins", irq_status, 8'h08);
    irq_clear = 8'h08; tick(); idle();
    check_eq("clear_alone", irq_status, 8'h00);
    check_eq("clear_irq", irq, 1'b0);

    // Masked write and simultaneous oe write
    out_we = 1'b1; out_wdata = 8'hFF; out_wmask = 8'hFF; tick();
    out_wdata = 8'hA5; out_wmask = 8'h0F; oe_we = 1'b1; oe_wdata = 8'hFF; tick(); idle();
    check_eq("masked_write", gpio.value_out, 8'hF5);
    check_eq("oe_write", gpio.output_enable, 8'hFF);

    // Loopback on bit2
    oe_we = 1'b1; oe_wdata = 8'h04; out_we = 1'b1; out_wdata = 8'h00; out_wmask = 8'hFF;
    gpio.value_in = 8'h00; tick(); idle(); ticks(6);
    out_we = 1'b1; out_wdata = 8'h04; out_wmask = 8'h04; tick(); idle(); ticks(8);
`ifdef PZVIP_GPIO_LOOPBACK_EN
    check_eq("loopback_bit2", value_filtered[2], 1'b1);
`else
    check_eq("loopback_bit2", value_filtered[2], 1'b0);
`endif

    // Random traffic
    for (int unsigned c = 0; c < 700; c++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      if (c % 50 == 0) begin
        debounce_cycles = 8'($urandom_range(0, 5));
        irq_rise_en = 8'($urandom);
        irq_fall_en = 8'($urandom);
      end
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) gpio.value_in[b] = ~gpio.value_in[b];
      if ($urandom_range(0, 7) == 0) irq_clear = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        out_we = 1'b1; out_wdata = 8'($urandom); out_wmask = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        oe_we = 1'b1; oe_wdata = 8'($urandom);
      end
      tick();
    end
    reset = 1'b0; idle();
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
